mcu1_core: RTL
==============

# mcu1_core

Parametrised second-generation accumulator MCU core, successor to the MCU0-Mini. It runs a 16-opcode accumulator ISA with configurable word and address widths. It talks to memory over a single request/ready bus with arbitrary wait states, which replaces the fixed-timing tristate bus. It sits between the top-level testbench or SoC shell and any memory model that implements the handshake below.

## Interface
Parameters:
- DW, 16, data and instruction word width; multiple of 8, at least 16.
- AW, 12, byte-address width; AW ≤ DW-4.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  AW  byte address of the word.
- mem_wdata  out  DW  store data; valid while mem_req && mem_we.
- mem_rdata  in  DW  read data; sampled on the cycle mem_req && mem_ready.
- mem_ready  in  1  transfer completes on a rising edge where mem_req && mem_ready.
- halted  out  1  core is in HALT.
- pc_dbg  out  AW  current PC.
- acc_dbg  out  DW  accumulator A.

## Operation
- Registers: A (DW bits), PC (AW bits), flags N and Z, IR (DW bits). Instruction format: OP = IR[DW-1:DW-4], C = IR[DW-5:0]. Operand address = C[AW-1:0]. M = memory word at that address.
- Opcodes:
  - 0 LD: A=M.
  - 1 ADD: A=A+M.
  - 2 JMP: PC=C.
  - 3 ST: M=A.
  - 4 CMP: N=(A<M) unsigned, Z=(A==M).
  - 5 JEQ: if Z, PC=C.
  - 6 SUB: A=A-M.
  - 7 JLT: if N, PC=C.
  - 8 AND, 9 OR, A XOR: A = A op M.
  - B SHL: A=A<<C[3:0].
  - C LDI: A=zero-extend(C).
  - D JNE: if !Z, PC=C.
  - E NOP.
  - F HALT.
- Only CMP writes N and Z. Arithmetic is modulo 2^DW. PC increments by DW/8 and wraps modulo 2^AW.
- State machine:
  - FETCH: mem_req=1, we=0, addr=PC. On ready, IR=mem_rdata, PC=PC+DW/8, go to DECODE.
  - DECODE: jumps, LDI, SHL and NOP execute here and go to FETCH. HALT goes to HALT. LD/ADD/SUB/AND/OR/XOR/CMP/ST go to MEM.
  - MEM: mem_req=1, addr=C. ST drives we=1 and wdata=A. On ready, a read op applies its result (or flags), then go to FETCH.
  - HALT: no requests; halted=1; left only by reset.
- Reset values: state=FETCH, PC=RESET_PC, A=0, N=Z=0, IR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.

## Timing
- Bus outputs are registered. mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the completing edge. mem_req drops, or moves to the next transfer, on the following cycle.
- mem_ready is ignored while mem_req=0.
- With zero wait states, mem_ready is already high when mem_req rises:
  - jumps, LDI, SHL and NOP take 2 cycles per instruction;
  - memory-operand ops take 3 cycles;
  - each wait cycle adds 1 cycle.
- The first mem_req rises on the first rising edge after reset_n deasserts.
- reset_n asserted mid-transfer drops mem_req asynchronously. The abandoned transfer has no architectural effect, and the memory must tolerate it.
- A jump taken in DECODE makes the very next FETCH use the new PC. There is no prefetch and no delay slot.
- ST to the address of the next instruction: the following FETCH reads the new value.

## Structure
- Package mcu1_pkg holds:
  - the opcode enum (4 bits);
  - the state enum {FETCH, DECODE, MEM, HALT};
  - helpers for OP/C field extraction.
- Sub-module mcu1_alu (combinational): inputs op, A, M and C; outputs result, N and Z. It serves both DECODE (LDI, SHL) and MEM.
- The bench memory model mcu1_mem is parameterised by DW, AW and WAIT (a fixed number of ready-delay cycles), plus an optional random-wait mode. It is initialised with $readmemh.

## Test plan
- Zero-wait program: LDI 5, ADD [0x100]=3, ST [0x102], HALT. Expect A=8, mem[0x102]=8, halted after 2+3+3+2 cycles, and no mem_req after HALT.
- WAIT=3 on the same program: identical final state; every memory op adds 3 cycles; addr, we and wdata never change while req is high without ready.
- Branches: A=7, CMP [M=7] then JEQ 0x040 → PC=0x040. CMP [M=9] sets N=1, Z=0; JLT is taken; JNE is taken; JEQ is not taken, so PC advances by 2.
- Wrap: DW=16, AW=8, RESET_PC=0xFE, with the instruction at 0xFE being NOP. The next fetch is at addr 0x00. ADD 0xFFFF+0x0002 gives A=0x0001 with flags unchanged.
- Reset mid-MEM: assert reset_n low while an ST is waiting for ready. mem_req falls in the same cycle and memory is unchanged. After release, fetch starts at RESET_PC with A=0.
- DW=32, AW=16 build: LDI 0x0ABCDEF, SHL 4 → A=0x0ABCDEF0, and PC steps by 4.

Source files
------------

// File: rtl/mcu1_pkg.sv
// Shared types and instruction-field helpers for the MCU1 accumulator core.
package mcu1_pkg;

    // Upper bound on DW supported by the field helpers below.
    localparam int unsigned MaxDw = 64;

    typedef enum logic [3:0] {
        OpLd   = 4'h0,
        OpAdd  = 4'h1,
        OpJmp  = 4'h2,
        OpSt   = 4'h3,
        OpCmp  = 4'h4,
        OpJeq  = 4'h5,
        OpSub  = 4'h6,
        OpJlt  = 4'h7,
        OpAnd  = 4'h8,
        OpOr   = 4'h9,
        OpXor  = 4'hA,
        OpShl  = 4'hB,
        OpLdi  = 4'hC,
        OpJne  = 4'hD,
        OpNop  = 4'hE,
        OpHalt = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        StFetch,
        StDecode,
        StMem,
        StHalt
    } state_e;

    function automatic op_e get_op(input logic [MaxDw-1:0] ir, input int unsigned dw);
        return op_e'(4'(ir >> (dw - 4)));
    endfunction

    function automatic logic [MaxDw-1:0] get_c(input logic [MaxDw-1:0] ir,
                                               input int unsigned dw);
        return ir & ((MaxDw'(1) << (dw - 4)) - MaxDw'(1));
    endfunction

endpackage

// File: rtl/mcu1_alu.sv
// Combinational datapath: accumulator results for register/memory ops and CMP flags.
module mcu1_alu
    import mcu1_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] m,
    input  logic [DW-1:0] c,
    output logic [DW-1:0] result,
    output logic          n,
    output logic          z
);

    always_comb begin
        result = a;
        n      = (a < m);
        z      = (a == m);
        case (op)
            OpLd:    result = m;
            OpAdd:   result = a + m;
            OpSub:   result = a - m;
            OpAnd:   result = a & m;
            OpOr:    result = a | m;
            OpXor:   result = a ^ m;
            OpShl:   result = a << c[3:0];
            OpLdi:   result = c;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/mcu1_core.sv
// MCU1 accumulator core: fetch/decode/memory FSM driving a registered req/ready bus.
module mcu1_core
    import mcu1_pkg::*;
#(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   AW       = 12,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          halted,
    output logic [AW-1:0] pc_dbg,
    output logic [DW-1:0] acc_dbg
);

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] ir_q;
    logic          n_q;
    logic          z_q;

    op_e           op;
    logic [DW-1:0] c_full;
    logic [AW-1:0] c_addr;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] next_pc;
    logic          taken;
    logic          mem_op;
    logic [DW-1:0] alu_result;
    logic          alu_n;
    logic          alu_z;

    assign op      = get_op(MaxDw'(ir_q), DW);
    assign c_full  = DW'(get_c(MaxDw'(ir_q), DW));
    assign c_addr  = c_full[AW-1:0];
    assign pc_inc  = pc_q + AW'(DW / 8);
    assign mem_op  = op inside {OpLd, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpCmp, OpSt};
    // pc_q already points past the current instruction when DECODE evaluates this.
    assign next_pc = taken ? c_addr : pc_q;
    assign pc_dbg  = pc_q;
    assign acc_dbg = acc_q;

    always_comb begin
        taken = 1'b0;
        case (op)
            OpJmp:   taken = 1'b1;
            OpJeq:   taken = z_q;
            OpJlt:   taken = n_q;
            OpJne:   taken = !z_q;
            default: taken = 1'b0;
        endcase
    end

    mcu1_alu #(
        .DW(DW)
    ) u_alu (
        .op    (op),
        .a     (acc_q),
        .m     (mem_rdata),
        .c     (c_full),
        .result(alu_result),
        .n     (alu_n),
        .z     (alu_z)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            acc_q     <= '0;
            ir_q      <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    // Only reached with mem_req low straight out of reset.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_q;
                    end else if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_inc;
                        mem_req <= 1'b0;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (op == OpHalt) begin
                        halted  <= 1'b1;
                        state_q <= StHalt;
                    end else if (mem_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OpSt);
                        mem_addr  <= c_addr;
                        mem_wdata <= acc_q;
                        state_q   <= StMem;
                    end else begin
                        if (op == OpLdi || op == OpShl) begin
                            acc_q <= alu_result;
                        end
                        pc_q     <= next_pc;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= next_pc;
                        state_q  <= StFetch;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        if (op == OpCmp) begin
                            n_q <= alu_n;
                            z_q <= alu_z;
                        end else if (op != OpSt) begin
                            acc_q <= alu_result;
                        end
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_q;
                        state_q  <= StFetch;
                    end
                end
                StHalt: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
